// File: rtl/lamp_pkg.sv
// Purpose : shared definitions for the running-lamp generator and detector.
// Latency : n/a (types, constants and pure functions only).
// Flow    : n/a. Holds mode codes, sequence periods, detector FSM state type
//           and lamp_expected(mode, step), the per-step lamp value.
package lamp_pkg;

   localparam logic [1:0] MODE_BOUNCE   = 2'd0;
   localparam logic [1:0] MODE_BLINK    = 2'd1;
   localparam logic [1:0] MODE_FILL     = 2'd2;
   localparam logic [1:0] MODE_CONVERGE = 2'd3;

   localparam int PERIOD_BOUNCE   = 7;
   localparam int PERIOD_BLINK    = 4;
   localparam int PERIOD_FILL     = 16;
   localparam int PERIOD_CONVERGE = 8;

   typedef enum logic [1:0] {
      ST_HUNT,
      ST_PAIR,
      ST_VERIFY,
      ST_LOCK
   } det_state_t;

   function automatic int lamp_period(logic [1:0] mode);
      case (mode)
         MODE_BOUNCE: return PERIOD_BOUNCE;
         MODE_BLINK:  return PERIOD_BLINK;
         MODE_FILL:   return PERIOD_FILL;
         default:     return PERIOD_CONVERGE;
      endcase
   endfunction

   // Step after 'step', wrapping at the end of the mode's sequence.
   function automatic logic [3:0] lamp_next_step(logic [1:0] mode, logic [3:0] step);
      if (int'(step) + 1 >= lamp_period(mode)) return 4'd0;
      return step + 4'd1;
   endfunction

   function automatic logic [7:0] lamp_expected(logic [1:0] mode, logic [3:0] step);
      logic [7:0] v;
      v = 8'h00;
      case (mode)
         MODE_BOUNCE: case (step)
            4'd0: v = 8'h18; 4'd1: v = 8'h24; 4'd2: v = 8'h42; 4'd3: v = 8'h81;
            4'd4: v = 8'h42; 4'd5: v = 8'h24; 4'd6: v = 8'h18;
            default: v = 8'h00;
         endcase
         MODE_BLINK: case (step)
            4'd0: v = 8'hAA; 4'd1: v = 8'h00; 4'd2: v = 8'h55; 4'd3: v = 8'h00;
            default: v = 8'h00;
         endcase
         MODE_FILL: case (step)
            4'd0:  v = 8'h80; 4'd1:  v = 8'hC0; 4'd2:  v = 8'hE0; 4'd3:  v = 8'hF0;
            4'd4:  v = 8'hF8; 4'd5:  v = 8'hFC; 4'd6:  v = 8'hFE; 4'd7:  v = 8'hFF;
            4'd8:  v = 8'h7F; 4'd9:  v = 8'h3F; 4'd10: v = 8'h1F; 4'd11: v = 8'h0F;
            4'd12: v = 8'h07; 4'd13: v = 8'h03; 4'd14: v = 8'h01; default: v = 8'h00;
         endcase
         default: case (step)
            4'd0: v = 8'h81; 4'd1: v = 8'hC3; 4'd2: v = 8'hE7; 4'd3: v = 8'hFF;
            4'd4: v = 8'h7E; 4'd5: v = 8'h3C; 4'd6: v = 8'h18; default: v = 8'h00;
         endcase
      endcase
      return v;
   endfunction

endpackage

// File: rtl/lamp_pattern_detector_if.sv
// Purpose : lamp bus plus detector status, as seen between the LED bus side
//           (master drives lamp_in/lamp_strobe) and the detector (slave).
// Ports   : lamp_in[7:0], lamp_strobe -> detector; mode_det[1:0], step_det[3:0],
//           locked, err_pulse, err_cnt[ERR_W-1:0] <- detector.
interface lamp_pattern_detector_if #(parameter int ERR_W = 8);
   import lamp_pkg::*;

   logic [7:0]       lamp_in;
   logic             lamp_strobe;
   logic [1:0]       mode_det;
   logic [3:0]       step_det;
   logic             locked;
   logic             err_pulse;
   logic [ERR_W-1:0] err_cnt;

   modport master (
      output lamp_in, lamp_strobe,
      input  mode_det, step_det, locked, err_pulse, err_cnt
   );

   modport slave (
      input  lamp_in, lamp_strobe,
      output mode_det, step_det, locked, err_pulse, err_cnt
   );
endinterface

// File: rtl/lamp_pair_lookup.sv
// Purpose : identify mode and step from two consecutive lamp samples.
// Latency : combinational.
// Ports   : prev[7:0], cur[7:0] in; hit, mode[1:0], step[3:0] (index of cur) out.
module lamp_pair_lookup
   import lamp_pkg::*;
(
   input  logic [7:0] prev,
   input  logic [7:0] cur,
   output logic       hit,
   output logic [1:0] mode,
   output logic [3:0] step
);

   // Pairs are unique across all modes (wrap pairs included), so at most
   // one (mode, step) can match and no priority is needed.
   always_comb begin
      hit  = 1'b0;
      mode = 2'd0;
      step = 4'd0;
      for (int m = 0; m < 4; m++) begin
         for (int s = 0; s < 16; s++) begin
            if (s < lamp_period(2'(m))) begin
               if (lamp_expected(2'(m), 4'((s == 0) ? lamp_period(2'(m)) - 1 : s - 1)) == prev &&
                   lamp_expected(2'(m), 4'(s)) == cur) begin
                  hit  = 1'b1;
                  mode = 2'(m);
                  step = 4'(s);
               end
            end
         end
      end
   end

endmodule

// File: rtl/lamp_pattern_detector.sv
// Purpose : detect which running-lamp mode is on the bus, track its step,
//           flag and count deviations once locked.
// Latency : 1 clk from strobe to outputs; 3 clk from the external strobe edge
//           when LAMP_DET_SYNC_EN is defined (2-flop sync + edge detect).
// Ports   : clk, reset (async, active-high), bus (slave modport).
module lamp_pattern_detector
   import lamp_pkg::*;
#(
   parameter int LOCK_MATCHES = 3,
   parameter int ERR_W        = 8
)(
   input  logic                    clk,
   input  logic                    reset,
   lamp_pattern_detector_if.slave  bus
);

   logic [7:0] sample;
   logic       strobe;

`ifdef LAMP_DET_SYNC_EN
   logic [7:0] lamp_s1, lamp_s2;
   logic       stb_s1, stb_s2, stb_s3;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lamp_s1 <= '0;
         lamp_s2 <= '0;
         stb_s1  <= 1'b0;
         stb_s2  <= 1'b0;
         stb_s3  <= 1'b0;
      end else begin
         lamp_s1 <= bus.lamp_in;
         lamp_s2 <= lamp_s1;
         stb_s1  <= bus.lamp_strobe;
         stb_s2  <= stb_s1;
         stb_s3  <= stb_s2;
      end
   end

   // One sample per strobe rising edge, however long the strobe stays high.
   assign sample = lamp_s2;
   assign strobe = stb_s2 & ~stb_s3;
`else
   assign sample = bus.lamp_in;
   assign strobe = bus.lamp_strobe;
`endif

   det_state_t       state;
   logic [7:0]       prev;
   logic [1:0]       mode_q;
   logic [3:0]       step_q;
   logic [3:0]       match_q;
   logic             locked_q;
   logic             err_q;
   logic [ERR_W-1:0] cnt_q;

   logic             lk_hit;
   logic [1:0]       lk_mode;
   logic [3:0]       lk_step;
   logic [3:0]       nxt_step;
   logic             exp_ok;

   lamp_pair_lookup u_lookup (
      .prev (prev),
      .cur  (sample),
      .hit  (lk_hit),
      .mode (lk_mode),
      .step (lk_step)
   );

   assign nxt_step = lamp_next_step(mode_q, step_q);
   assign exp_ok   = (sample == lamp_expected(mode_q, nxt_step));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_HUNT;
         prev     <= 8'h00;
         mode_q   <= 2'd0;
         step_q   <= 4'd0;
         match_q  <= 4'd0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         err_q <= 1'b0;
         if (strobe) begin
            case (state)
               ST_HUNT: begin
                  prev  <= sample;
                  state <= ST_PAIR;
               end
               ST_PAIR: begin
                  if (lk_hit) begin
                     mode_q  <= lk_mode;
                     step_q  <= lk_step;
                     match_q <= 4'd0;
                     state   <= ST_VERIFY;
                  end else begin
                     prev <= sample;
                  end
               end
               ST_VERIFY: begin
                  if (exp_ok) begin
                     step_q  <= nxt_step;
                     match_q <= match_q + 4'd1;
                     if (match_q + 4'd1 == 4'(LOCK_MATCHES)) begin
                        state    <= ST_LOCK;
                        locked_q <= 1'b1;
                     end
                  end else begin
                     // Acquisition failure is not an error; just re-pair.
                     prev  <= sample;
                     state <= ST_PAIR;
                  end
               end
               ST_LOCK: begin
                  if (exp_ok) begin
                     step_q <= nxt_step;
                  end else begin
                     err_q    <= 1'b1;
                     if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                     locked_q <= 1'b0;
                     prev     <= sample;
                     state    <= ST_PAIR;
                  end
               end
               default: state <= ST_HUNT;
            endcase
         end
      end
   end

   assign bus.mode_det  = mode_q;
   assign bus.step_det  = step_q;
   assign bus.locked    = locked_q;
   assign bus.err_pulse = err_q;
   assign bus.err_cnt   = cnt_q;

endmodule

// File: tb/tb_lamp_pattern_detector.sv
// Purpose : self-checking bench for lamp_pattern_detector (default build).
// Stimulus: hand tables, multi-cycle corner sequences and a random stream.
// Reference: sequence tables plus a pair search over them, tracked per sample.
module tb_lamp_pattern_detector;

   logic clk;
   logic reset;

   lamp_pattern_detector_if #(.ERR_W(8)) bus ();

   lamp_pattern_detector #(.LOCK_MATCHES(3), .ERR_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp;
   int n_bad;

   // ---------------- reference model ----------------
   logic [7:0] seq [4][16];
   int         per [4];

   bit         m_have_prev, m_tracking, m_locked, m_err;
   int         m_mode, m_step, m_matches, m_errs;
   logic [7:0] m_prev;

   task automatic model_reset();
      m_have_prev = 0; m_tracking = 0; m_locked = 0; m_err = 0;
      m_mode = 0; m_step = 0; m_matches = 0; m_errs = 0; m_prev = 8'h00;
   endtask

   task automatic model_step(input logic [7:0] s);
      bit found;
      m_err = 0;
      if (!m_have_prev) begin
         m_prev = s;
         m_have_prev = 1;
      end else if (!m_tracking) begin
         found = 0;
         for (int m = 0; m < 4; m++)
            for (int k = 0; k < per[m]; k++)
               if (!found && seq[m][(k + per[m] - 1) % per[m]] == m_prev && seq[m][k] == s) begin
                  found = 1; m_mode = m; m_step = k;
               end
         if (found) begin
            m_tracking = 1; m_matches = 0;
         end else begin
            m_prev = s;
         end
      end else if (s == seq[m_mode][(m_step + 1) % per[m_mode]]) begin
         m_step = (m_step + 1) % per[m_mode];
         if (!m_locked) begin
            m_matches++;
            if (m_matches == 3) m_locked = 1;
         end
      end else begin
         if (m_locked) begin
            m_err = 1;
            if (m_errs < 255) m_errs++;
         end
         m_locked = 0; m_tracking = 0; m_prev = s;
      end
   endtask

   // ---------------- check helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_model();
      chk("mode_det",  32'(bus.mode_det),  32'(m_mode));
      chk("step_det",  32'(bus.step_det),  32'(m_step));
      chk("locked",    32'(bus.locked),    32'(m_locked));
      chk("err_pulse", 32'(bus.err_pulse), 32'(m_err));
      chk("err_cnt",   32'(bus.err_cnt),   32'(m_errs));
   endtask

   // Called just after a posedge; drives one strobed sample and checks the
   // result #1 after the next posedge, so back-to-back calls give 1 sample/clk.
   task automatic send(input logic [7:0] s);
      bus.lamp_in = s;
      bus.lamp_strobe = 1'b1;
      model_step(s);
      @(posedge clk); #1;
      bus.lamp_strobe = 1'b0;
      chk_model();
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         m_err = 0;
         chk("idle_err_pulse", 32'(bus.err_pulse), 32'd0);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.lamp_strobe = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk_model();
   endtask

   task automatic run_random(input int bursts);
      int m, s, len;
      logic [7:0] v;
      for (int r = 0; r < bursts; r++) begin
         m   = $urandom_range(0, 3);
         s   = $urandom_range(0, per[m] - 1);
         len = $urandom_range(3, 20);
         for (int k = 0; k < len; k++) begin
            v = seq[m][(s + k) % per[m]];
            if ($urandom_range(0, 15) == 0) v = 8'($urandom);
            send(v);
            idle($urandom_range(0, 2));
         end
      end
   endtask

   // ---------------- table-driven vectors ----------------
   typedef struct {
      logic [7:0] lamp;
      logic [1:0] mode;
      logic [3:0] step;
      logic       locked;
      logic [7:0] cnt;
   } vec_t;

   vec_t tab_blink [6];
   vec_t tab_wrap  [7];

   task automatic run_table(input string name, input vec_t v);
      send(v.lamp);
      chk({name, "_mode"},   32'(bus.mode_det), 32'(v.mode));
      chk({name, "_step"},   32'(bus.step_det), 32'(v.step));
      chk({name, "_locked"}, 32'(bus.locked),   32'(v.locked));
      chk({name, "_cnt"},    32'(bus.err_cnt),  32'(v.cnt));
      idle(3);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      per[0] = 7; per[1] = 4; per[2] = 16; per[3] = 8;
      seq[0] = '{8'h18,8'h24,8'h42,8'h81,8'h42,8'h24,8'h18,0,0,0,0,0,0,0,0,0};
      seq[1] = '{8'hAA,8'h00,8'h55,8'h00,0,0,0,0,0,0,0,0,0,0,0,0};
      seq[2] = '{8'h80,8'hC0,8'hE0,8'hF0,8'hF8,8'hFC,8'hFE,8'hFF,
                 8'h7F,8'h3F,8'h1F,8'h0F,8'h07,8'h03,8'h01,8'h00};
      seq[3] = '{8'h81,8'hC3,8'hE7,8'hFF,8'h7E,8'h3C,8'h18,8'h00,0,0,0,0,0,0,0,0};

      tab_blink[0] = '{8'hAA, 2'd0, 4'd0, 1'b0, 8'd0};
      tab_blink[1] = '{8'h00, 2'd1, 4'd1, 1'b0, 8'd0};
      tab_blink[2] = '{8'h55, 2'd1, 4'd2, 1'b0, 8'd0};
      tab_blink[3] = '{8'h00, 2'd1, 4'd3, 1'b0, 8'd0};
      tab_blink[4] = '{8'hAA, 2'd1, 4'd0, 1'b1, 8'd0};
      tab_blink[5] = '{8'h00, 2'd1, 4'd1, 1'b1, 8'd0};

      tab_wrap[0] = '{8'h81, 2'd0, 4'd0, 1'b0, 8'd0};
      tab_wrap[1] = '{8'h42, 2'd0, 4'd4, 1'b0, 8'd0};
      tab_wrap[2] = '{8'h24, 2'd0, 4'd5, 1'b0, 8'd0};
      tab_wrap[3] = '{8'h18, 2'd0, 4'd6, 1'b0, 8'd0};
      tab_wrap[4] = '{8'h18, 2'd0, 4'd0, 1'b1, 8'd0};
      tab_wrap[5] = '{8'h24, 2'd0, 4'd1, 1'b1, 8'd0};
      tab_wrap[6] = '{8'h42, 2'd0, 4'd2, 1'b1, 8'd0};

      bus.lamp_in = 8'h00;
      bus.lamp_strobe = 1'b0;
      reset = 1'b1;
      #2;
      do_reset();
      chk("reset_mode",   32'(bus.mode_det), 32'd0);
      chk("reset_locked", 32'(bus.locked),   32'd0);

      // Blink stream with a strobe every 4 clks.
      foreach (tab_blink[i]) run_table("blink", tab_blink[i]);

      // Bounce stream across the 18,18 wrap.
      do_reset();
      foreach (tab_wrap[i]) run_table("wrap", tab_wrap[i]);

      // Fill: lock, inject 55 where F0 is due, then resume and relock.
      do_reset();
      for (int k = 0; k < 16; k++) send(seq[2][k]);
      send(8'h80); send(8'hC0); send(8'hE0);
      chk("fill_locked_pre", 32'(bus.locked), 32'd1);
      send(8'h55);
      chk("fill_err_pulse", 32'(bus.err_pulse), 32'd1);
      chk("fill_err_cnt",   32'(bus.err_cnt),   32'd1);
      chk("fill_unlocked",  32'(bus.locked),    32'd0);
      idle(1);
      chk("fill_pulse_one_clk", 32'(bus.err_pulse), 32'd0);
      send(8'hF8); send(8'hFC); send(8'hFE); send(8'hFF); send(8'h7F);
      chk("fill_relock",      32'(bus.locked),   32'd1);
      chk("fill_relock_mode", 32'(bus.mode_det), 32'd2);

      // Converge locked up to 3C, then the stream switches to bounce.
      do_reset();
      for (int k = 0; k < 6; k++) send(seq[3][k]);
      chk("conv_locked", 32'(bus.locked),   32'd1);
      chk("conv_step",   32'(bus.step_det), 32'd5);
      send(8'h42);
      chk("switch_err", 32'(bus.err_cnt), 32'd1);
      send(8'h81); send(8'h42); send(8'h24); send(8'h18);
      chk("switch_relock", 32'(bus.locked),   32'd1);
      chk("switch_mode",   32'(bus.mode_det), 32'd0);

      // Error counter saturation.
      do_reset();
      for (int it = 0; it < 256; it++) begin
         send(8'hAA); send(8'h00); send(8'h55); send(8'h00); send(8'hAA);
         send(8'hFF);
      end
      chk("sat_at_max", 32'(bus.err_cnt), 32'hFF);
      send(8'hAA); send(8'h00); send(8'h55); send(8'h00); send(8'hAA);
      send(8'hFF);
      chk("sat_hold", 32'(bus.err_cnt), 32'hFF);

      // Async reset while locked with err_cnt = 5.
      do_reset();
      for (int it = 0; it < 5; it++) begin
         send(8'hAA); send(8'h00); send(8'h55); send(8'h00); send(8'hAA);
         send(8'hFF);
      end
      send(8'hAA); send(8'h00); send(8'h55); send(8'h00); send(8'hAA);
      chk("pre_reset_locked", 32'(bus.locked),  32'd1);
      chk("pre_reset_cnt",    32'(bus.err_cnt), 32'd5);
      #2 reset = 1'b1;
      #1;
      chk("async_locked", 32'(bus.locked),   32'd0);
      chk("async_cnt",    32'(bus.err_cnt),  32'd0);
      chk("async_mode",   32'(bus.mode_det), 32'd0);
      chk("async_step",   32'(bus.step_det), 32'd0);
      model_reset();
      @(posedge clk); #1 reset = 1'b0;
      send(8'h80); send(8'hC0); send(8'hE0); send(8'hF0); send(8'hF8);
      chk("post_reset_relock", 32'(bus.locked), 32'd1);

      // Randomized streams against the model.
      do_reset();
      run_random(60);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lamp_pattern_detector.md
Name: lamp_pattern_detector

Overview:
- Receive-side companion to the running-lamp generator: observes the 8-bit lamp bus once per lamp step.
- Identifies which of the four lamp modes is running and tracks the step index.
- Flags any deviation from the expected sequence and counts errors.
- Sits on the board/test side of the LED bus; used for self-check and for display of the detected mode.

Parameters:
- LOCK_MATCHES, 3: consecutive correct predictions required in VERIFY before declaring lock (range 1..15).
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- lamp_in  in  8  observed lamp bus, bit 7 = leftmost lamp
- lamp_strobe  in  1  one-clk pulse; lamp_in is valid and is sampled on this cycle
- mode_det  out  2  detected mode code (00/01/10/11)
- step_det  out  4  step index of the most recent sample within the mode's sequence
- locked  out  1  high while in LOCK
- err_pulse  out  1  one-clk pulse on a mismatch while in LOCK
- err_cnt  out  ERR_W  saturating count of err_pulse events

Behaviour:
- Mode sequences (step 0 first, hex; wrap to step 0 after the last step):
  - Mode 0, period 7: 18,24,42,81,42,24,18
  - Mode 1, period 4: AA,00,55,00
  - Mode 2, period 16: 80,C0,E0,F0,F8,FC,FE,FF,7F,3F,1F,0F,07,03,01,00
  - Mode 3, period 8: 81,C3,E7,FF,7E,3C,18,00
- Every (previous, current) consecutive sample pair is unique across all modes, including wrap pairs (e.g. 18,18 is mode 0 step 6 to step 0; 00,81 is mode 3 step 7 to step 0). Acquisition uses pair lookup only.
- All state and outputs change only on clk edges where lamp_strobe=1. The exception is err_pulse, which self-clears after one cycle. Results are visible the cycle after the strobe.
- FSM states:
  - HUNT: no previous sample. On strobe, store the sample and go to PAIR.
  - PAIR: on strobe, look up (prev, cur).
    - Hit: load mode/step (step = index of cur), match counter = 0, go to VERIFY.
    - Miss: prev <= cur, stay in PAIR.
  - VERIFY: on strobe, compare against the expected value at step+1 (mod period).
    - Match: advance step and increment the match counter. On reaching LOCK_MATCHES, go to LOCK and assert locked.
    - Mismatch: prev <= cur, go to PAIR. No error is counted.
  - LOCK: on strobe, compare against the expected value at step+1.
    - Match: advance step.
    - Mismatch: err_pulse = 1 for one cycle, err_cnt += 1 (saturates at all-ones, no wrap), locked drops, prev <= cur, go to PAIR.
- mode_det and step_det hold their last values outside VERIFY/LOCK; they are meaningful only when locked=1.
- Strobe on two consecutive clocks: each is a separate sample. The FSM must sustain one sample per clk.
- Mode switch at the generator mid-stream: the generator keeps its step counter, so the post-switch stream starts at an arbitrary step. The detector takes exactly one error and then reacquires through PAIR.
- Generator reset output 00 followed by a mode start is handled naturally by pair lookup. A lone 00 never produces a hit.
- Reset (async, any state) forces:
  - state = HUNT, prev = 00
  - mode_det = 00, step_det = 0
  - locked = 0, err_pulse = 0, err_cnt = 0
  - match counter = 0

Optional Feature:
- Macro: LAMP_DET_SYNC_EN.
- Defined: lamp_in and lamp_strobe pass through two-flop synchronizers. lamp_strobe is then rising-edge detected internally, so a multi-cycle-high strobe yields one sample. Adds 3 clk latency from the external strobe edge to the outputs.
- Undefined: inputs are used directly. lamp_strobe is level-sampled each clk. Latency is 1 clk.

Decomposition:
- Shared package lamp_pkg:
  - mode code constants (MODE_BOUNCE=0, MODE_BLINK=1, MODE_FILL=2, MODE_CONVERGE=3)
  - period constants per mode
  - FSM state typedef
  - function lamp_expected(mode, step) returning 8 bits
- The generator should reuse lamp_pkg.
- One sub-module, lamp_pair_lookup: combinational. Input (prev, cur); outputs hit, mode, step.

Test Plan:
- Mode 1 stream AA,00,55,00,AA,00 with a strobe every 4 clks -> locked=1 after the 5th sample (pair hit + 3 matches), mode_det=01, step_det=1 after the 6th sample, err_cnt=0.
- Mode 0 stream across a wrap, 81,42,24,18,18,24,42 -> hit at (81,42) with step 4. The 18,18 pair is accepted as a wrap. locked=1, mode_det=00, step_det=2 after the last sample.
- Locked on mode 2, inject 55 in place of expected F0 -> err_pulse for exactly 1 clk, err_cnt=1, locked=0. Resuming F8,FC,FE,FF,7F relocks with mode_det=10.
- Locked on mode 3 at step 5 (3C), then the stream switches to mode 0 values -> one error, reacquire with mode_det=00 within 5 strobes.
- Force err_cnt to 2^ERR_W-1 via repeated mismatches, then one more mismatch -> err_cnt stays FF (ERR_W=8).
- Assert reset while in LOCK with err_cnt=5 -> all outputs zero asynchronously, before the next clk edge. The next valid stream relocks normally.
